// File: rtl/mips_cpu_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_lsu
//  Description : Fetch/data load-store unit bridging the multicycle MIPS core
//                to one Avalon-MM master port. Data requests have priority
//                over fetch. Byte-enable/lane replication for stores, load
//                merging for LB/LBU/LH/LHU/LW/LWL/LWR, alignment and bus
//                timeout error reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter bit          CHECK_ALIGN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic        d_req,
    input  logic [3:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [31:0] d_rt,
    output logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    localparam logic [3:0]  OP_LB  = 4'd0;
    localparam logic [3:0]  OP_LBU = 4'd1;
    localparam logic [3:0]  OP_LH  = 4'd2;
    localparam logic [3:0]  OP_LHU = 4'd3;
    localparam logic [3:0]  OP_LW  = 4'd4;
    localparam logic [3:0]  OP_LWL = 4'd5;
    localparam logic [3:0]  OP_LWR = 4'd6;
    localparam logic [3:0]  OP_SB  = 4'd8;
    localparam logic [3:0]  OP_SH  = 4'd9;
    localparam logic [3:0]  OP_SW  = 4'd10;
    localparam logic [31:0] C_TO_LIM = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_fetch;
    logic [3:0]  r_op;
    logic [29:0] r_waddr;
    logic [1:0]  r_b;
    logic [31:0] r_wdata, r_rt, r_cnt;
    logic        r_if_valid, r_d_valid, r_err;
    logic [1:0]  r_err_code;
    logic [31:0] r_if_data, r_d_rdata;

    // Request selection and decode in IDLE (fetch is carried as a word load)
    logic [3:0]  w_op;
    logic [31:0] w_addr;
    logic [1:0]  w_b, w_b_eff, w_code;
    logic        w_is_half, w_is_word, w_illegal, w_mis, w_err_idle, w_to;

    assign w_op       = d_req ? d_op : OP_LW;
    assign w_addr     = d_req ? d_addr : if_addr;
    assign w_b        = w_addr[1:0];
    assign w_is_half  = (w_op == OP_LH) || (w_op == OP_LHU) || (w_op == OP_SH);
    assign w_is_word  = (w_op == OP_LW) || (w_op == OP_SW);
    assign w_illegal  = d_req && ((d_op == 4'd7) || (d_op > OP_SW));
    assign w_mis      = (w_is_half && w_b[0]) || (w_is_word && (w_b != 2'b00));
    assign w_err_idle = w_illegal || (CHECK_ALIGN && w_mis);
    assign w_code     = w_illegal ? 2'd3 : 2'd1;
    // With alignment checking off, offsets are forced to the nearest legal lane
    assign w_b_eff    = (!CHECK_ALIGN && w_is_half) ? {w_b[1], 1'b0} :
                        (!CHECK_ALIGN && w_is_word) ? 2'b00 : w_b;
    assign w_to       = (TIMEOUT_CYCLES != 0) && waitrequest && (r_cnt == C_TO_LIM);

    // Lane enables and replicated store data for the registered access
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    always_comb begin
        w_be = 4'b1111;
        w_wd = r_wdata;
        case (r_op)
            OP_LB, OP_LBU, OP_SB: w_be = 4'b0001 << r_b;
            OP_LH, OP_LHU, OP_SH: w_be = 4'b0011 << r_b;
            default:              w_be = 4'b1111;
        endcase
        case (r_op)
            OP_SB:   w_wd = {4{r_wdata[7:0]}};
            OP_SH:   w_wd = {2{r_wdata[15:0]}};
            default: w_wd = r_wdata;
        endcase
    end

    // Load result formed from readdata in the cycle it is accepted
    logic [4:0]  w_sh_r, w_sh_l;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    always_comb begin
        w_sh_r = {r_b, 3'b000};
        w_sh_l = {2'd3 - r_b, 3'b000};
        w_byte = 8'(readdata >> w_sh_r);
        w_half = 16'(readdata >> w_sh_r);
        case (r_op)
            OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load = {24'd0, w_byte};
            OP_LH:   w_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load = {16'd0, w_half};
            OP_LWL:  w_load = (readdata << w_sh_l) | (r_rt & ((32'h1 << w_sh_l) - 32'h1));
            OP_LWR:  w_load = (readdata >> w_sh_r) | (r_rt & ~(32'hFFFF_FFFF >> w_sh_r));
            default: w_load = readdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state and combinational request handshakes
    always_comb begin
        w_state_next = r_state;
        d_ready      = 1'b0;
        if_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                d_ready  = d_req;
                if_ready = if_req && !d_req;
                if (d_req || if_req) w_state_next = w_err_idle ? S_DONE : S_BUS;
            end
            S_BUS:   if (!waitrequest || w_to) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request capture, wait counting and registered completion outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch    <= 1'b0;
            r_op       <= 4'd0;
            r_waddr    <= 30'd0;
            r_b        <= 2'd0;
            r_wdata    <= 32'd0;
            r_rt       <= 32'd0;
            r_cnt      <= 32'd0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_if_data  <= 32'd0;
            r_d_rdata  <= 32'd0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            case (r_state)
                S_IDLE: if (d_req || if_req) begin
                    r_fetch <= !d_req;
                    r_op    <= w_op;
                    r_waddr <= w_addr[31:2];
                    r_b     <= w_b_eff;
                    r_wdata <= d_wdata;
                    r_rt    <= d_rt;
                    r_cnt   <= 32'd0;
                    if (w_err_idle) begin
                        r_err      <= 1'b1;
                        r_err_code <= w_code;
                        if (d_req) begin
                            r_d_valid <= 1'b1;
                            r_d_rdata <= 32'd0;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_data  <= 32'd0;
                        end
                    end
                end
                S_BUS: begin
                    if (!waitrequest) begin
                        if (r_fetch) begin
                            r_if_valid <= 1'b1;
                            r_if_data  <= readdata;
                        end else begin
                            r_d_valid <= 1'b1;
                            r_d_rdata <= r_op[3] ? 32'd0 : w_load;
                        end
                    end else if (w_to) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                        if (r_fetch) begin
                            r_if_valid <= 1'b1;
                            r_if_data  <= 32'd0;
                        end else begin
                            r_d_valid <= 1'b1;
                            r_d_rdata <= 32'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_valid   = r_if_valid;
    assign if_data    = r_if_data;
    assign d_valid    = r_d_valid;
    assign d_rdata    = r_d_rdata;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign busy       = (r_state != S_IDLE);
    assign read       = (r_state == S_BUS) && !r_op[3];
    assign write      = (r_state == S_BUS) && r_op[3];
    assign address    = (r_state == S_BUS) ? {r_waddr, 2'b00} : 32'd0;
    assign byteenable = (r_state == S_BUS) ? w_be : 4'd0;
    assign writedata  = (r_state == S_BUS) ? w_wd : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cpu_lsu
//  Description : Self-checking bench for mips_cpu_lsu with a byte-level
//                reference model, directed and randomized transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ready, if_valid;
    logic [31:0] if_addr, if_data;
    logic        d_req, d_ready, d_valid;
    logic [3:0]  d_op;
    logic [31:0] d_addr, d_wdata, d_rt, d_rdata;
    logic        err, busy, read, write, waitrequest;
    logic [1:0]  err_code;
    logic [31:0] address, writedata, readdata;
    logic [3:0]  byteenable;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_cpu_lsu #(.TIMEOUT_CYCLES(4), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_valid(if_valid), .if_data(if_data),
        .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rt(d_rt), .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
        .err(err), .err_code(err_code), .busy(busy),
        .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-lane view) ----------------
    function automatic int size_of(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd8: return 1;
            4'd2, 4'd3, 4'd9: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic bit legal(input logic [3:0] op);
        return (op <= 4'd6) || (op >= 4'd8 && op <= 4'd10);
    endfunction

    function automatic bit misal(input logic [3:0] op, input int b);
        if (size_of(op) == 2) return (b % 2) != 0;
        if (op == 4'd4 || op == 4'd10) return b != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input int b);
        logic [3:0] be = 4'd0;
        if (op == 4'd5 || op == 4'd6) return 4'hF;
        for (int j = 0; j < 4; j++) be[j] = (j >= b) && (j < b + size_of(op));
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [3:0] op, input logic [31:0] wd);
        logic [31:0] r = 32'd0;
        int s = size_of(op);
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = wd[(j % s)*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input int b,
                                           input logic [31:0] m, input logic [31:0] rt);
        int mb [4];
        int v;
        logic [31:0] r = rt;
        for (int j = 0; j < 4; j++) mb[j] = int'(m[j*8 +: 8]);
        case (op)
            4'd0, 4'd1: begin
                v = mb[b];
                if (op == 4'd0 && v >= 128) v = v - 256;
                return 32'(v);
            end
            4'd2, 4'd3: begin
                v = mb[b] + 256 * mb[b+1];
                if (op == 4'd2 && v >= 32768) v = v - 65536;
                return 32'(v);
            end
            4'd5: begin
                for (int j = 3 - b; j < 4; j++) r[j*8 +: 8] = 8'(mb[j - (3 - b)]);
                return r;
            end
            4'd6: begin
                for (int j = 0; j <= 3 - b; j++) r[j*8 +: 8] = 8'(mb[j + b]);
                return r;
            end
            default: return m;
        endcase
    endfunction

    // ---------------- transaction drivers ----------------
    task automatic do_data(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rt,
                           input logic [31:0] m, input int waits);
        int  b     = int'(addr[1:0]);
        bit  e_err = !legal(op) || misal(op, b);
        d_req = 1'b1; d_op = op; d_addr = addr; d_wdata = wd; d_rt = rt;
        #1;
        chk("d_ready", d_ready, 1);
        chk("if_ready_blocked", if_ready, 0);
        @(posedge clk); #1;
        d_req = 1'b0; d_op = 4'($urandom); d_addr = $urandom; d_wdata = $urandom; d_rt = $urandom;
        if (e_err) begin
            chk("err_valid", d_valid, 1);
            chk("err_flag", err, 1);
            chk("err_code", err_code, legal(op) ? 32'd1 : 32'd3);
            chk("err_nobus", {read, write}, 0);
            chk("err_rdata", d_rdata, 0);
        end else begin
            for (int i = 0; i <= waits; i++) begin
                waitrequest = (i < waits);
                readdata    = (i < waits) ? $urandom : m;
                chk("cmd_read", read, (op < 4'd8) ? 32'd1 : 32'd0);
                chk("cmd_write", write, (op >= 4'd8) ? 32'd1 : 32'd0);
                chk("address", address, {addr[31:2], 2'b00});
                chk("byteenable", byteenable, m_be(op, b));
                if (op >= 4'd8) chk("writedata", writedata, m_wd(op, wd));
                chk("no_early_valid", d_valid, 0);
                @(posedge clk); #1;
            end
            waitrequest = 1'b0;
            chk("d_valid", d_valid, 1);
            chk("d_err", err, 0);
            chk("d_rdata", d_rdata, (op >= 4'd8) ? 32'd0 : m_load(op, b, m, rt));
            chk("cmd_drop", {read, write}, 0);
        end
        @(posedge clk); #1;
        chk("d_valid_pulse", d_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] m, input int waits);
        if_req = 1'b1; if_addr = addr;
        #1;
        chk("if_ready", if_ready, 1);
        @(posedge clk); #1;
        if_req = 1'b0; if_addr = $urandom;
        if (addr[1:0] != 2'b00) begin
            chk("if_err_valid", if_valid, 1);
            chk("if_err", err, 1);
            chk("if_err_code", err_code, 1);
            chk("if_err_nobus", read, 0);
        end else begin
            for (int i = 0; i <= waits; i++) begin
                waitrequest = (i < waits);
                readdata    = (i < waits) ? $urandom : m;
                chk("if_read", read, 1);
                chk("if_address", address, addr);
                chk("if_be", byteenable, 4'hF);
                @(posedge clk); #1;
            end
            waitrequest = 1'b0;
            chk("if_valid", if_valid, 1);
            chk("if_data", if_data, m);
            chk("if_noerr", err, 0);
        end
        @(posedge clk); #1;
        chk("if_valid_pulse", if_valid, 0);
    endtask

    logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};

    initial begin
        int n;
        logic [3:0]  op;
        logic [31:0] a;
        reset = 1'b0; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_op = 4'd0;
        d_addr = 32'd0; d_wdata = 32'd0; d_rt = 32'd0; waitrequest = 1'b0; readdata = 32'd0;
        #1;
        chk("rst_outputs", {28'd0, if_valid, d_valid, err, busy}, 0);
        chk("rst_bus", {30'd0, read, write}, 0);
        chk("rst_address", address, 0);
        chk("rst_rdata", d_rdata | if_data, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        do_fetch(32'hBFC0_0000, 32'h2402_000A, 0);
        do_data(4'd0, 32'h0000_1003, 32'd0, 32'd0, 32'h80FF_0102, 0);
        do_data(4'd1, 32'h0000_1003, 32'd0, 32'd0, 32'h80FF_0102, 1);
        do_data(4'd5, 32'h0000_2001, 32'd0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        do_data(4'd6, 32'h0000_2001, 32'd0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        do_data(4'd9, 32'h0000_3002, 32'h0000_BEEF, 32'd0, 32'h1234_5678, 3);
        do_data(4'd8, 32'h0000_3001, 32'h0000_00A5, 32'd0, 32'd0, 0);
        do_data(4'd10, 32'h0000_3004, 32'hDEAD_BEEF, 32'd0, 32'd0, 2);

        // Simultaneous requests: data first, held fetch taken in next IDLE
        if_req = 1'b1; if_addr = 32'h0040_0010;
        do_data(4'd4, 32'h0000_5000, 32'd0, 32'd0, 32'hCAFE_F00D, 0);
        do_fetch(32'h0040_0010, 32'h0123_4567, 1);

        // Error paths: misaligned, illegal ops, misaligned fetch
        do_data(4'd4, 32'h0000_4002, 32'd0, 32'd0, 32'd0, 0);
        do_data(4'd3, 32'h0000_4001, 32'd0, 32'd0, 32'd0, 0);
        do_data(4'd7, 32'h0000_4000, 32'd0, 32'd0, 32'd0, 0);
        do_data(4'd15, 32'h0000_4000, 32'd0, 32'd0, 32'd0, 0);
        do_fetch(32'h0040_0002, 32'd0, 0);

        // Randomized legal traffic
        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 9)];
            a  = $urandom;
            if (size_of(op) == 2) a[0] = 1'b0;
            if (op == 4'd4 || op == 4'd10) a[1:0] = 2'b00;
            if ($urandom_range(0, 4) == 0) begin
                a[1:0] = 2'b00;
                do_fetch(a, $urandom, $urandom_range(0, 2));
            end else begin
                do_data(op, a, $urandom, $urandom, $urandom, $urandom_range(0, 2));
            end
        end

        // Timeout with waitrequest stuck high
        d_req = 1'b1; d_op = 4'd4; d_addr = 32'h0000_6000;
        @(posedge clk); #1;
        d_req = 1'b0; waitrequest = 1'b1; n = 0;
        for (int i = 0; i < 20 && !d_valid; i++) begin
            if (read) n++;
            @(posedge clk); #1;
        end
        chk("to_read_cycles", n, 4);
        chk("to_valid", d_valid, 1);
        chk("to_err", err, 1);
        chk("to_code", err_code, 2);
        chk("to_rdata", d_rdata, 0);
        waitrequest = 1'b0;
        @(posedge clk); #1;

        // Reset asserted in the middle of a bus transfer
        d_req = 1'b1; d_op = 4'd4; d_addr = 32'h0000_7000;
        @(posedge clk); #1;
        d_req = 1'b0; waitrequest = 1'b1;
        chk("pre_rst_read", read, 1);
        reset = 1'b0;
        #1;
        chk("rst_read_drop", read, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b1; waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_no_valid", {d_valid, if_valid}, 0);
            @(posedge clk); #1;
        end
        do_data(4'd2, 32'h0000_8002, 32'd0, 32'd0, 32'h8001_7FFF, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mips_cpu_lsu.md
# mips_cpu_lsu

Load/store and fetch unit between the multicycle MIPS core and the Avalon memory-mapped bus. It serves two request channels, instruction fetch and data, over one Avalon master port, with fixed data-over-fetch priority. It generates `byteenable` and lane-replicated `writedata` for byte, half and word stores. It merges load data for LB/LBU/LH/LHU/LW/LWL/LWR (little-endian), and reports misalignment and bus-timeout errors, which the current core does not detect.

## Interface
- `TIMEOUT_CYCLES`, 256: `waitrequest` cycles tolerated per transfer before abort; 0 disables the timeout.
- `CHECK_ALIGN`, 1: 1 = trap misaligned LH/LHU/SH/LW/SW/fetch; 0 = force address bits low and proceed.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `if_req` in 1: fetch request.
- `if_addr` in 32: fetch byte address.
- `if_ready` out 1: fetch accepted this cycle.
- `if_valid` out 1: one-cycle pulse, `if_data` valid.
- `if_data` out 32: fetched word.
- `d_req` in 1: data request.
- `d_op` in 4: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; others illegal.
- `d_addr` in 32: byte address.
- `d_wdata` in 32: store data (rt).
- `d_rt` in 32: current rt, for the LWL/LWR merge.
- `d_ready` out 1: data request accepted this cycle.
- `d_valid` out 1: one-cycle completion pulse, for loads and stores.
- `d_rdata` out 32: load result; 0 for stores and errors.
- `err` out 1: qualifies `if_valid`/`d_valid`; transfer failed.
- `err_code` out 2: 1 misaligned, 2 timeout, 3 illegal op.
- `busy` out 1: state ≠ IDLE.
- `address` out 32: Avalon word address, bits [1:0] = 0.
- `read` out 1, `write` out 1: Avalon commands.
- `waitrequest` in 1: Avalon stall.
- `writedata` out 32, `byteenable` out 4: Avalon write data and lane enables.
- `readdata` in 32: Avalon read data, valid in the cycle `waitrequest` is low.

## Operation
- States: IDLE, BUS, DONE.
- IDLE:
  - `d_ready` = `d_req`.
  - `if_ready` = `if_req` & !`d_req` (data wins).
  - The accepted request's op, address, byte offset b = addr[1:0], `d_wdata` and `d_rt` are registered.
  - An illegal op or a misaligned access (CHECK_ALIGN=1) goes directly to DONE with `err`=1 and no bus cycle.
  - Misaligned cases: half with b[0]=1; word/fetch with b≠0.
  - Otherwise go to BUS.
- BUS:
  - `read` or `write` is held, with `address`/`byteenable`/`writedata` stable, until `waitrequest` is low.
  - On that edge `readdata` is captured and the state goes to DONE.
  - A cycle counter increments per cycle with `waitrequest` high. On reaching TIMEOUT_CYCLES, commands drop and the state goes to DONE with `err_code`=2.
- DONE: the appropriate `*_valid` is high for one cycle with the result, then IDLE.
- Byte enables:
  - SB/LB/LBU: 1<<b.
  - SH/LH/LHU: 0011<<b.
  - Word, LWL, LWR and fetch: 1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load results (m = captured readdata):
  - LB/LBU: byte b, sign- or zero-extended.
  - LH/LHU: halfword at b, sign- or zero-extended.
  - LW: m.
  - LWL: (m << 8(3−b)) | (rt & (2^(8(3−b))−1)).
  - LWR: (m >> 8b) | (rt & ~(FFFFFFFF >> 8b)).
- CHECK_ALIGN=0: b is masked to legal bits (half: b[0]=0; word: b=0) before any use.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. Reset asserted mid-transfer drops `read`/`write` asynchronously and abandons the transfer with no valid pulse.
- `*_ready` is combinational in IDLE only. Requests in BUS/DONE are ignored; the requester holds `*_req`.
- Zero-wait latency:
  - Cycle 0: accept.
  - Cycle 1: BUS, command asserted.
  - Cycle 2: DONE, valid high.
  - Each `waitrequest` cycle adds one.
- Error latency: accept → valid next cycle.
- Throughput: one transfer per 3 cycles minimum.
- Outputs in DONE are registered. `if_data`/`d_rdata` hold their value until the next DONE.
- Simultaneous `if_req` and `d_req` in IDLE: data served; fetch accepted in the next IDLE.
- A timeout with TIMEOUT_CYCLES=N: the command is high for exactly N cycles, then DONE.

## Test plan
- Fetch at BFC00000, readdata 2402000A, no wait: `read` high at cycle 1 with `address` BFC00000 and `byteenable` 1111; `if_valid` at cycle 2 with `if_data` 2402000A, `err`=0.
- LB addr 00001003, readdata 80FF0102: `byteenable` 1000, `d_rdata` FFFFFF80. LBU at the same address: 00000080.
- LWL addr …01, m=44332211, rt=AABBCCDD: `d_rdata` 2211CCDD. LWR addr …01, same m and rt: AA443322.
- SH addr …02, wdata 0000BEEF, `waitrequest` high 3 cycles: `write` held 4 cycles, `writedata` BEEFBEEF, `byteenable` 1100, `d_valid` 1 cycle after release, `d_rdata`=0.
- Both requests in IDLE: `d_ready`=1 and `if_ready`=0. LW addr …02 with CHECK_ALIGN=1 gives no bus cycle and `d_valid`+`err` with code 1 next cycle.
- TIMEOUT_CYCLES=4 with `waitrequest` stuck high: `read` high 4 cycles, then `err_code`=2. `reset` low mid-BUS: `read`=0 immediately, no valid pulse.
